// File: rtl/envelope_vca.sv
`default_nettype none
// ============================================================================
// envelope_vca : ADSR envelope generator stepped by Tick, driving an output VCA
// Revision     : 1.0
// ============================================================================
module envelope_vca #(
   parameter int WAVE_DEPTH = 8,
   parameter int ENV_DEPTH  = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  tick_i,
   input  logic                  gate_i,
   input  logic [WAVE_DEPTH-1:0] attack_i,
   input  logic [WAVE_DEPTH-1:0] decay_i,
   input  logic [WAVE_DEPTH-1:0] sustain_i,
   input  logic [WAVE_DEPTH-1:0] release_i,
   input  logic [WAVE_DEPTH-1:0] waveform_i,
   output logic [WAVE_DEPTH-1:0] audio_o,
   output logic [WAVE_DEPTH-1:0] level_o,
   output logic [2:0]            state_o,
   output logic                  active_o
);

   localparam int                   SHIFT     = ENV_DEPTH - WAVE_DEPTH;
   localparam logic [2:0]           S_IDLE    = 3'd0;
   localparam logic [2:0]           S_ATTACK  = 3'd1;
   localparam logic [2:0]           S_DECAY   = 3'd2;
   localparam logic [2:0]           S_SUSTAIN = 3'd3;
   localparam logic [2:0]           S_RELEASE = 3'd4;
   localparam logic [ENV_DEPTH-1:0] ENV_MAX   = {ENV_DEPTH{1'b1}};

   logic [2:0]              state_q, state_d;
   logic [ENV_DEPTH-1:0]    env_q, env_d;
   logic                    gate_q;
   logic [WAVE_DEPTH-1:0]   audio_q, audio_d;
   logic [WAVE_DEPTH-1:0]   level;
   logic                    rise, fall;
   logic [ENV_DEPTH-1:0]    sus, att, dec, rel;
   logic [ENV_DEPTH:0]      att_sum, dec_floor;
   logic [2*WAVE_DEPTH-1:0] prod;

   assign rise      = gate_i & ~gate_q;
   assign fall      = ~gate_i & gate_q;
   assign sus       = {sustain_i, {SHIFT{1'b0}}};
   assign att       = {{SHIFT{1'b0}}, attack_i};
   assign dec       = {{SHIFT{1'b0}}, decay_i};
   assign rel       = {{SHIFT{1'b0}}, release_i};
   assign att_sum   = {1'b0, env_q} + {1'b0, att};
   // env - Decay <= SUS rewritten as env <= SUS + Decay so nothing can borrow
   assign dec_floor = {1'b0, sus} + {1'b0, dec};
   assign level     = env_q[ENV_DEPTH-1 -: WAVE_DEPTH];

   assign prod    = {{WAVE_DEPTH{1'b0}}, waveform_i}
                  * ({{(WAVE_DEPTH-1){1'b0}}, 1'b0, level} + {{(2*WAVE_DEPTH-1){1'b0}}, 1'b1});
   assign audio_d = WAVE_DEPTH'(prod >> WAVE_DEPTH);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         env_q   <= '0;
         gate_q  <= 1'b0;
         audio_q <= '0;
      end else begin
         state_q <= state_d;
         env_q   <= env_d;
         gate_q  <= gate_i;
         audio_q <= audio_d;
      end
   end

   always_comb begin
      state_d = state_q;
      env_d   = env_q;
      if (rise) begin
         state_d = S_ATTACK;
      end else if (fall) begin
         if (state_q == S_ATTACK || state_q == S_DECAY || state_q == S_SUSTAIN)
            state_d = S_RELEASE;
      end else if (tick_i) begin
         // A zero rate freezes the segment entirely, including its exit test
         case (state_q)
            S_IDLE: env_d = '0;
            S_ATTACK: begin
               if (attack_i != '0) begin
                  if (att_sum >= {1'b0, ENV_MAX}) begin
                     env_d   = ENV_MAX;
                     state_d = S_DECAY;
                  end else begin
                     env_d = att_sum[ENV_DEPTH-1:0];
                  end
               end
            end
            S_DECAY: begin
               if (decay_i != '0) begin
                  if ({1'b0, env_q} <= dec_floor) begin
                     env_d   = sus;
                     state_d = S_SUSTAIN;
                  end else begin
                     env_d = env_q - dec;
                  end
               end
            end
            S_SUSTAIN: env_d = sus;
            S_RELEASE: begin
               if (release_i != '0) begin
                  if (env_q <= rel) begin
                     env_d   = '0;
                     state_d = S_IDLE;
                  end else begin
                     env_d = env_q - rel;
                  end
               end
            end
            default: begin
               env_d   = '0;
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      level_o  = level;
      state_o  = state_q;
      active_o = (state_q != S_IDLE);
      audio_o  = audio_q;
   end

endmodule
`default_nettype wire
